// File: rtl/prim_assembly_pkg.sv
// Shared types and constants for primitive assembly: opcodes, vertex/bbox packing, setup widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prim_assembly_pkg;

  // Opcodes forwarded by the vertex stage
  localparam int OPCODE_WIDTH = 8;
  localparam logic [OPCODE_WIDTH-1:0] OP_NOP            = 8'h00;
  localparam logic [OPCODE_WIDTH-1:0] OP_SETCOLOR       = 8'h10;
  localparam logic [OPCODE_WIDTH-1:0] OP_SETVERTEX      = 8'h11;
  localparam logic [OPCODE_WIDTH-1:0] OP_BEGINPRIMITIVE = 8'h20;
  localparam logic [OPCODE_WIDTH-1:0] OP_ENDPRIMITIVE   = 8'h21;
  localparam logic [OPCODE_WIDTH-1:0] OP_FLUSH          = 8'h30;
  localparam logic [OPCODE_WIDTH-1:0] OP_DRAW           = 8'h31;

  localparam int COORD_W = 16;           // signed screen coordinate
  localparam int VREG_W  = 64;           // vertex / colour register
  localparam int DELTA_W = COORD_W + 1;  // edge deltas never overflow
  localparam int AREA_W  = 35;           // full-precision cross product

  typedef logic signed [COORD_W-1:0] coord_t;

  // Vertex as presented to the rasterizer: {y,x}
  typedef struct packed {
    coord_t y;
    coord_t x;
  } vtx_t;

  typedef struct packed {
    coord_t ymax;
    coord_t ymin;
    coord_t xmax;
    coord_t xmin;
  } bbox_t;

  function automatic coord_t coord_min3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic coord_t coord_max3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

endpackage

// File: rtl/prim_assembly_if.sv
// Bundle between vertex stage / rasterizer and primitive assembly.
// Latency: n/a (wires only).
// Backpressure: O_FRAMESTALL holds upstream, I_RastReady drains the triangle slot.
interface prim_assembly_if;
  import prim_assembly_pkg::*;

  // Upstream side
  logic                    I_LOCK;
  logic [OPCODE_WIDTH-1:0] I_Opcode;
  logic [VREG_W-1:0]       I_VIn;
  logic [VREG_W-1:0]       I_ColorIn;
  logic                    O_FRAMESTALL;
  logic                    O_LOCK;

  // Rasterizer side
  logic                    I_RastReady;
  logic                    O_TriValid;
  logic [31:0]             O_V0;
  logic [31:0]             O_V1;
  logic [31:0]             O_V2;
  logic [VREG_W-1:0]       O_Color;
  logic [63:0]             O_BBox;
  logic                    O_FrameDone;

  // master: the assembly stage itself (drives the triangle slot)
  modport master (
    input  I_LOCK, I_Opcode, I_VIn, I_ColorIn, I_RastReady,
    output O_TriValid, O_V0, O_V1, O_V2, O_Color, O_BBox,
           O_FrameDone, O_FRAMESTALL, O_LOCK
  );

  // slave: the surrounding pipeline (vertex stage + rasterizer)
  modport slave (
    output I_LOCK, I_Opcode, I_VIn, I_ColorIn, I_RastReady,
    input  O_TriValid, O_V0, O_V1, O_V2, O_Color, O_BBox,
           O_FrameDone, O_FRAMESTALL, O_LOCK
  );

endinterface

// File: rtl/prim_assembly_tri_setup.sv
// Triangle setup: signed area, CCW reorder, bounding box.
// Latency: purely combinational.
// Backpressure: none.
module prim_assembly_tri_setup
  import prim_assembly_pkg::*;
(
  input  vtx_t  v0,
  input  vtx_t  v1,
  input  vtx_t  v2,
  output logic  area_zero,
  output logic  area_neg,
  output vtx_t  o_v0,
  output vtx_t  o_v1,
  output vtx_t  o_v2,
  output bbox_t bbox
);

  logic signed [DELTA_W-1:0] dx1, dy1, dx2, dy2;
  logic signed [AREA_W-1:0]  area;

  // Edge deltas are one bit wider than coordinates so they never wrap
  assign dx1 = DELTA_W'(v1.x) - DELTA_W'(v0.x);
  assign dy1 = DELTA_W'(v1.y) - DELTA_W'(v0.y);
  assign dx2 = DELTA_W'(v2.x) - DELTA_W'(v0.x);
  assign dy2 = DELTA_W'(v2.y) - DELTA_W'(v0.y);

  // Twice the signed area; 35 bits holds the extreme difference of two 34-bit products
  assign area = AREA_W'(dx1) * AREA_W'(dy2) - AREA_W'(dx2) * AREA_W'(dy1);

  assign area_zero = (area == '0);
  assign area_neg  = area[AREA_W-1];

  // Clockwise input is turned CCW by swapping the last two vertices
  assign o_v0 = v0;
  assign o_v1 = area_neg ? v2 : v1;
  assign o_v2 = area_neg ? v1 : v2;

  assign bbox.xmin = coord_min3(v0.x, v1.x, v2.x);
  assign bbox.xmax = coord_max3(v0.x, v1.x, v2.x);
  assign bbox.ymin = coord_min3(v0.y, v1.y, v2.y);
  assign bbox.ymax = coord_max3(v0.y, v1.y, v2.y);

endmodule

// File: rtl/prim_assembly.sv
// Groups SETVERTEX stream into a triangle list, culls zero-area, emits one CCW triangle + bbox.
// Latency: triangle valid after the negedge consuming its third vertex; one triangle per cycle.
// Backpressure: O_FRAMESTALL = slot full and rasterizer not ready; all inputs ignored while set.
module prim_assembly
  import prim_assembly_pkg::*;
(
  input  logic             I_CLOCK,
  input  logic             I_RESET,
  prim_assembly_if.master  pa
);

  localparam logic [1:0] VCNT_LAST = 2'd2;

  // Assembly state
  logic              in_prim_q, in_prim_d;
  logic [1:0]        vcnt_q, vcnt_d;
  vtx_t              vb0_q, vb0_d;
  vtx_t              vb1_q, vb1_d;
  logic [VREG_W-1:0] color_q, color_d;
  logic              draw_pend_q, draw_pend_d;

  // Output slot
  logic              tri_vld_q, tri_vld_d;
  vtx_t              out_v0_q, out_v0_d;
  vtx_t              out_v1_q, out_v1_d;
  vtx_t              out_v2_q, out_v2_d;
  logic [VREG_W-1:0] out_color_q, out_color_d;
  bbox_t             bbox_q, bbox_d;
  logic              frame_done_q, frame_done_d;

  logic  stall, accept, handover;
  logic  capture, tri_load, draw_req, draw_owed;
  vtx_t  vin;
  logic  unused_vin;

  logic  area_zero, area_neg;
  vtx_t  set_v0, set_v1, set_v2;
  bbox_t set_bbox;

  assign vin        = pa.I_VIn[47:16];
  assign unused_vin = ^{pa.I_VIn[63:48], pa.I_VIn[15:0]};

  assign stall    = tri_vld_q & ~pa.I_RastReady;
  assign accept   = pa.I_LOCK & ~stall;
  assign handover = pa.I_LOCK & tri_vld_q & pa.I_RastReady;

  assign capture  = accept & (pa.I_Opcode == OP_SETVERTEX) & in_prim_q & (vcnt_q == VCNT_LAST);
  assign tri_load = capture & ~area_zero;
  assign draw_req = accept & (pa.I_Opcode == OP_DRAW);
  // A DRAW behind an occupied slot waits for that triangle to be taken
  assign draw_owed = draw_pend_q | (draw_req & tri_vld_q);

  prim_assembly_tri_setup u_tri_setup (
    .v0        (vb0_q),
    .v1        (vb1_q),
    .v2        (vin),
    .area_zero (area_zero),
    .area_neg  (area_neg),
    .o_v0      (set_v0),
    .o_v1      (set_v1),
    .o_v2      (set_v2),
    .bbox      (set_bbox)
  );

  // Opcode decode: primitive bracketing, colour register, vertex buffer
  always_comb begin
    in_prim_d = in_prim_q;
    vcnt_d    = vcnt_q;
    vb0_d     = vb0_q;
    vb1_d     = vb1_q;
    color_d   = color_q;
    if (accept) begin
      case (pa.I_Opcode)
        OP_BEGINPRIMITIVE: begin
          in_prim_d = 1'b1;
          vcnt_d    = 2'd0;
        end
        OP_ENDPRIMITIVE, OP_FLUSH: begin
          in_prim_d = 1'b0;
          vcnt_d    = 2'd0;
        end
        OP_SETCOLOR: color_d = pa.I_ColorIn;
        OP_SETVERTEX: begin
          if (in_prim_q) begin
            if (vcnt_q == 2'd0) begin
              vb0_d  = vin;
              vcnt_d = 2'd1;
            end else if (vcnt_q == 2'd1) begin
              vb1_d  = vin;
              vcnt_d = 2'd2;
            end else begin
              vcnt_d = 2'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Triangle slot and end-of-frame pulse; frozen entirely while I_LOCK is low
  always_comb begin
    tri_vld_d    = tri_vld_q;
    out_v0_d     = out_v0_q;
    out_v1_d     = out_v1_q;
    out_v2_d     = out_v2_q;
    out_color_d  = out_color_q;
    bbox_d       = bbox_q;
    frame_done_d = frame_done_q;
    draw_pend_d  = draw_pend_q;
    if (pa.I_LOCK) begin
      frame_done_d = 1'b0;
      if (handover) tri_vld_d = 1'b0;
      // A reload on the handover edge wins over the clear
      if (tri_load) begin
        tri_vld_d   = 1'b1;
        out_v0_d    = set_v0;
        out_v1_d    = set_v1;
        out_v2_d    = set_v2;
        out_color_d = color_q;
        bbox_d      = set_bbox;
      end
      if (draw_req && !tri_vld_q) frame_done_d = 1'b1;
      if (draw_owed) begin
        if (handover) begin
          frame_done_d = 1'b1;
          draw_pend_d  = 1'b0;
        end else begin
          draw_pend_d  = 1'b1;
        end
      end
    end
  end

  // State register, negedge like the rest of the pipeline
  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      in_prim_q    <= 1'b0;
      vcnt_q       <= 2'd0;
      vb0_q        <= '0;
      vb1_q        <= '0;
      color_q      <= '0;
      draw_pend_q  <= 1'b0;
      tri_vld_q    <= 1'b0;
      out_v0_q     <= '0;
      out_v1_q     <= '0;
      out_v2_q     <= '0;
      out_color_q  <= '0;
      bbox_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      in_prim_q    <= in_prim_d;
      vcnt_q       <= vcnt_d;
      vb0_q        <= vb0_d;
      vb1_q        <= vb1_d;
      color_q      <= color_d;
      draw_pend_q  <= draw_pend_d;
      tri_vld_q    <= tri_vld_d;
      out_v0_q     <= out_v0_d;
      out_v1_q     <= out_v1_d;
      out_v2_q     <= out_v2_d;
      out_color_q  <= out_color_d;
      bbox_q       <= bbox_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pa.O_TriValid   = tri_vld_q;
  assign pa.O_V0         = out_v0_q;
  assign pa.O_V1         = out_v1_q;
  assign pa.O_V2         = out_v2_q;
  assign pa.O_Color      = out_color_q;
  assign pa.O_BBox       = bbox_q;
  assign pa.O_FrameDone  = frame_done_q;
  assign pa.O_FRAMESTALL = stall;
  assign pa.O_LOCK       = pa.I_LOCK;

endmodule

// File: tb/tb_prim_assembly.sv
// Directed bench for prim_assembly: triangle forming, culling, winding, stall, draw, reset.
// Latency: inputs change 1ns after a negedge, outputs checked 1ns after the next negedge.
// Backpressure: I_RastReady driven directly to exercise O_FRAMESTALL.
module tb_prim_assembly;
  import prim_assembly_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  prim_assembly_if pa ();

  prim_assembly dut (
    .I_CLOCK (clk),
    .I_RESET (rst),
    .pa      (pa)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] vin(input int x, input int y);
    return {16'h0000, 16'(y), 16'(x), 16'h0000};
  endfunction

  function automatic logic [31:0] vtx(input int x, input int y);
    return {16'(y), 16'(x)};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [OPCODE_WIDTH-1:0] op, input logic [63:0] v);
    pa.I_Opcode = op;
    pa.I_VIn    = v;
    tick();
    pa.I_Opcode = OP_NOP;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst            = 1'b1;
    pa.I_LOCK      = 1'b1;
    pa.I_Opcode    = OP_NOP;
    pa.I_VIn       = '0;
    pa.I_ColorIn   = '0;
    pa.I_RastReady = 1'b1;
    tick();
    tick();
    check("rst_valid", pa.O_TriValid, 0);
    check("rst_v0",    pa.O_V0, 0);
    check("rst_v2",    pa.O_V2, 0);
    check("rst_bbox",  pa.O_BBox, 0);
    check("rst_color", pa.O_Color, 0);
    check("rst_done",  pa.O_FrameDone, 0);
    check("rst_stall", pa.O_FRAMESTALL, 0);
    rst = 1'b0;
    tick();

    // CCW right triangle
    pa.I_ColorIn = 64'hCAFE_F00D_1234_5678;
    issue(OP_SETCOLOR, '0);
    pa.I_ColorIn = '0;
    issue(OP_BEGINPRIMITIVE, '0);
    issue(OP_SETVERTEX, vin(0, 0));
    issue(OP_SETVERTEX, vin(10, 0));
    check("t1_partial", pa.O_TriValid, 0);
    issue(OP_SETVERTEX, vin(0, 10));
    check("t1_valid", pa.O_TriValid, 1);
    check("t1_v0",    pa.O_V0, vtx(0, 0));
    check("t1_v1",    pa.O_V1, vtx(10, 0));
    check("t1_v2",    pa.O_V2, vtx(0, 10));
    check("t1_bbox",  pa.O_BBox, 64'h000A_0000_000A_0000);
    check("t1_color", pa.O_Color, 64'hCAFE_F00D_1234_5678);
    check("t1_stall", pa.O_FRAMESTALL, 0);
    issue(OP_ENDPRIMITIVE, '0);
    check("t1_taken", pa.O_TriValid, 0);

    // Clockwise input is reordered
    issue(OP_BEGINPRIMITIVE, '0);
    issue(OP_SETVERTEX, vin(0, 0));
    issue(OP_SETVERTEX, vin(0, 10));
    issue(OP_SETVERTEX, vin(10, 0));
    check("cw_valid", pa.O_TriValid, 1);
    check("cw_v0",    pa.O_V0, vtx(0, 0));
    check("cw_v1",    pa.O_V1, vtx(10, 0));
    check("cw_v2",    pa.O_V2, vtx(0, 10));

    // Negative coordinates: signed bbox
    issue(OP_SETVERTEX, vin(-5, 3));
    issue(OP_SETVERTEX, vin(7, -2));
    issue(OP_SETVERTEX, vin(1, 9));
    check("neg_v0",   pa.O_V0, vtx(-5, 3));
    check("neg_v1",   pa.O_V1, vtx(7, -2));
    check("neg_bbox", pa.O_BBox, 64'h0009_FFFE_0007_FFFB);

    // Extreme coordinates: area needs more than 32 bits, still CCW
    issue(OP_SETVERTEX, vin(-32768, -32768));
    issue(OP_SETVERTEX, vin(32767, -32768));
    issue(OP_SETVERTEX, vin(-32768, 32767));
    check("wide_valid", pa.O_TriValid, 1);
    check("wide_v1",    pa.O_V1, 32'h8000_7FFF);
    check("wide_v2",    pa.O_V2, 32'h7FFF_8000);
    check("wide_bbox",  pa.O_BBox, 64'h7FFF_8000_7FFF_8000);

    // Collinear triangle is culled
    issue(OP_SETVERTEX, vin(0, 0));
    issue(OP_SETVERTEX, vin(5, 5));
    issue(OP_SETVERTEX, vin(10, 10));
    check("cull_valid", pa.O_TriValid, 0);

    // Partial triangle discarded by END; next primitive starts at v0
    issue(OP_SETVERTEX, vin(1, 1));
    issue(OP_SETVERTEX, vin(2, 5));
    issue(OP_ENDPRIMITIVE, '0);
    check("part_none", pa.O_TriValid, 0);
    issue(OP_BEGINPRIMITIVE, '0);
    issue(OP_SETVERTEX, vin(0, 0));
    check("part_vcnt0", pa.O_TriValid, 0);
    issue(OP_SETVERTEX, vin(10, 0));
    issue(OP_SETVERTEX, vin(0, 10));
    check("part_valid", pa.O_TriValid, 1);
    check("part_v1",    pa.O_V1, vtx(10, 0));
    tick();
    check("part_taken", pa.O_TriValid, 0);

    // Back-pressure: slot full, rasterizer not ready
    pa.I_RastReady = 1'b0;
    issue(OP_SETVERTEX, vin(0, 0));
    issue(OP_SETVERTEX, vin(10, 0));
    issue(OP_SETVERTEX, vin(0, 10));
    check("stall_valid", pa.O_TriValid, 1);
    check("stall_on",    pa.O_FRAMESTALL, 1);
    pa.I_Opcode = OP_SETVERTEX;
    pa.I_VIn    = vin(20, 20);
    tick();
    tick();
    tick();
    check("stall_hold",  pa.O_FRAMESTALL, 1);
    check("stall_v0",    pa.O_V0, vtx(0, 0));
    check("stall_v1",    pa.O_V1, vtx(10, 0));
    pa.I_RastReady = 1'b1;
    #1;
    check("stall_off", pa.O_FRAMESTALL, 0);
    tick();
    pa.I_Opcode = OP_NOP;
    check("stall_taken", pa.O_TriValid, 0);
    issue(OP_SETVERTEX, vin(30, 20));
    issue(OP_SETVERTEX, vin(20, 30));
    check("second_valid", pa.O_TriValid, 1);
    check("second_v0",    pa.O_V0, vtx(20, 20));
    check("second_v2",    pa.O_V2, vtx(20, 30));

    // DRAW behind a full slot pulses done once, on acceptance
    pa.I_RastReady = 1'b0;
    pa.I_Opcode    = OP_DRAW;
    tick();
    check("draw_wait_done", pa.O_FrameDone, 0);
    tick();
    check("draw_wait_vld",  pa.O_TriValid, 1);
    check("draw_wait_done2", pa.O_FrameDone, 0);
    pa.I_RastReady = 1'b1;
    tick();
    pa.I_Opcode = OP_NOP;
    check("draw_done",  pa.O_FrameDone, 1);
    check("draw_taken", pa.O_TriValid, 0);
    tick();
    check("draw_once",  pa.O_FrameDone, 0);
    issue(OP_DRAW, '0);
    check("draw_empty", pa.O_FrameDone, 1);
    tick();
    check("draw_empty_end", pa.O_FrameDone, 0);

    // I_LOCK low freezes the slot even with ready high
    issue(OP_SETVERTEX, vin(0, 0));
    issue(OP_SETVERTEX, vin(10, 0));
    issue(OP_SETVERTEX, vin(0, 10));
    pa.I_LOCK = 1'b0;
    #1;
    check("lock_out", pa.O_LOCK, 0);
    tick();
    tick();
    check("lock_hold", pa.O_TriValid, 1);
    pa.I_LOCK = 1'b1;
    tick();
    check("lock_release", pa.O_TriValid, 0);

    // Reset with the slot full
    pa.I_RastReady = 1'b0;
    issue(OP_SETVERTEX, vin(0, 0));
    issue(OP_SETVERTEX, vin(10, 0));
    issue(OP_SETVERTEX, vin(0, 10));
    check("rfull_valid", pa.O_TriValid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rfull_clear", pa.O_TriValid, 0);
    check("rfull_bbox",  pa.O_BBox, 0);
    check("rfull_stall", pa.O_FRAMESTALL, 0);
    rst = 1'b0;
    pa.I_RastReady = 1'b1;
    tick();
    issue(OP_SETVERTEX, vin(0, 0));
    issue(OP_SETVERTEX, vin(10, 0));
    issue(OP_SETVERTEX, vin(0, 10));
    check("rfull_noprim", pa.O_TriValid, 0);

    // Reset mid-primitive, then a clean primitive
    issue(OP_BEGINPRIMITIVE, '0);
    issue(OP_SETVERTEX, vin(1, 1));
    issue(OP_SETVERTEX, vin(2, 5));
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    issue(OP_BEGINPRIMITIVE, '0);
    issue(OP_SETVERTEX, vin(0, 0));
    check("rmid_first", pa.O_TriValid, 0);
    issue(OP_SETVERTEX, vin(10, 0));
    issue(OP_SETVERTEX, vin(0, 10));
    check("rmid_valid", pa.O_TriValid, 1);
    check("rmid_v0",    pa.O_V0, vtx(0, 0));
    check("rmid_v1",    pa.O_V1, vtx(10, 0));
    check("rmid_color", pa.O_Color, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prim_assembly.md
# prim_assembly

Primitive-assembly stage that sits directly downstream of the vertex transform stage and feeds the rasterizer. It consumes transformed vertices, the current colour and the forwarded opcode, and groups vertices issued between `OP_BEGINPRIMITIVE` and `OP_ENDPRIMITIVE` into a triangle list. For each triangle it computes a signed-area setup term, culls degenerate triangles, normalises winding to CCW and computes the bounding box. It presents one triangle at a time to the rasterizer over a valid/ready handshake and back-pressures upstream through the frame-stall line.

## Interface
- `COORD_W`, 16: signed coordinate width (`DATA_WIDTH`).
- `VREG_W`, 64: vertex/colour register width (`VREG_WIDTH`).
- `I_CLOCK` in 1: clock. All state updates on negedge, matching the pipeline.
- `I_RESET` in 1: reset, asynchronous, active-high.
- `I_LOCK` in 1: stage enable from upstream.
- `I_Opcode` in `OPCODE_WIDTH`: opcode forwarded by the vertex stage.
- `I_VIn` in `VREG_W`: transformed vertex. x=[31:16], y=[47:32], signed.
- `I_ColorIn` in `VREG_W`: colour from the vertex stage.
- `I_RastReady` in 1: rasterizer accepts the triangle.
- `O_TriValid` out 1: triangle slot occupied.
- `O_V0`/`O_V1`/`O_V2` out 32 each: vertices as {y,x}, CCW order.
- `O_Color` out `VREG_W`: triangle colour.
- `O_BBox` out 64: {ymax,ymin,xmax,xmin}.
- `O_FrameDone` out 1: one-cycle pulse marking the end of a frame.
- `O_FRAMESTALL` out 1: upstream hold.
- `O_LOCK` out 1: equals `I_LOCK`.

## Operation
- An input is consumed on an active edge: `I_LOCK`=1 and `O_FRAMESTALL`=0. When `O_FRAMESTALL`=1 all inputs are ignored; upstream holds them.
- `O_FRAMESTALL` = `O_TriValid & ~I_RastReady`. This is combinational.
- State: `in_prim` (1 bit), `vcnt` (0..2), vertex buffer `vb[0:1]`, `color_q`, `draw_pend`.
- `OP_BEGINPRIMITIVE`: `in_prim`←1, `vcnt`←0.
- `OP_ENDPRIMITIVE`: `in_prim`←0, `vcnt`←0. A partial triangle is discarded.
- `OP_SETCOLOR`: `color_q`←`I_ColorIn`.
- `OP_SETVERTEX`:
  - Ignored if `in_prim`=0.
  - If `vcnt`<2: `vb[vcnt]`←vertex, then `vcnt`++.
  - If `vcnt`=2: form a triangle from v0=`vb[0]`, v1=`vb[1]`, v2=input, and set `vcnt`←0.
- Setup, computed combinationally at capture:
  - dx1=x1−x0, dy1=y1−y0, dx2=x2−x0, dy2=y2−y0. Each is 17-bit signed.
  - A = dx1·dy2 − dx2·dy1, 35-bit signed, full precision, no truncation.
  - If A=0: cull. The slot is not loaded.
  - If A<0: swap v1 and v2 on output.
  - BBox is the signed min/max over the three x and the three y values.
  - `O_Color`←`color_q`. A `SETCOLOR` in the same cycle is not yet visible.
- Slot load: `O_TriValid`←1. On an edge with `O_TriValid & I_RastReady` the slot clears, unless it is reloaded on that same edge.
- `OP_FLUSH`: `in_prim`←0, `vcnt`←0. The occupied slot is kept.
- `OP_DRAW`:
  - If the slot is empty, `O_FrameDone` pulses the next cycle.
  - Otherwise `draw_pend`←1. `O_FrameDone` pulses on the cycle the pending triangle is accepted, then `draw_pend` clears.
- Other opcodes have no effect.

## Timing
- Reset values: `O_TriValid`=0, `O_V0`/`O_V1`/`O_V2`=0, `O_Color`=0, `O_BBox`=0, `O_FrameDone`=0, `in_prim`=0, `vcnt`=0, `color_q`=0, `draw_pend`=0. `O_FRAMESTALL` is 0 as a consequence.
- Latency: the third vertex is consumed on edge N; `O_TriValid` and the data are valid after edge N. Throughput is one triangle per cycle.
- The output data is stable while `O_TriValid`=1 and `I_RastReady`=0.
- A third vertex arriving when the slot is full and `I_RastReady`=1: the old triangle is handed over and the new one is loaded on the same edge.
- `I_LOCK`=0: state holds and no outputs change. `O_FRAMESTALL` still tracks the slot.
- Reset mid-primitive or with the slot full: everything returns to reset values and any pending triangle is lost.

## Structure
- The shared package / `global_def.h` holds:
  - opcode defines, already present;
  - `COORD_W`;
  - a packed vertex typedef {y,x};
  - a bbox typedef;
  - `AREA_W`=35.
- Sub-module `tri_setup`: purely combinational. It takes v0/v1/v2 and produces area sign/zero, reordered vertices and bbox. It is instantiated once.

## Test plan
- Begin, then vertices (0,0), (10,0), (0,10), then End. Required: `O_V0`=(0,0), `O_V1`=(10,0), `O_V2`=(0,10); bbox {10,0,10,0}; one valid cycle with ready=1.
- CW input (0,0), (0,10), (10,0). Required: output is v1=(10,0), v2=(0,10).
- Collinear (0,0), (5,5), (10,10) → no `O_TriValid`. Then 2 vertices followed by `ENDPRIMITIVE` → no triangle, and `vcnt` is back to 0.
- Ready held 0 with two triangles queued upstream. Required: `O_FRAMESTALL`=1, the outputs stay frozen, and the second triangle loads on the edge where ready rises.
- `OP_DRAW` while the slot is full and ready=0. Required: `O_FrameDone` pulses exactly once, on the acceptance cycle.
- Assert `I_RESET` after 2 vertices and a full slot. Required: `O_TriValid`=0 immediately; a subsequent 3-vertex primitive starts cleanly from v0.
